// File: rtl/mdu_issue_pkg.sv
// Shared definitions for the MDU issue stage: MIPS MDU op codes,
// issue FSM state encoding and op-class decode helpers.
package mdu_issue_pkg;

    localparam logic [5:0] MIPS_MFHI  = 6'h10;
    localparam logic [5:0] MIPS_MTHI  = 6'h11;
    localparam logic [5:0] MIPS_MFLO  = 6'h12;
    localparam logic [5:0] MIPS_MTLO  = 6'h13;
    localparam logic [5:0] MIPS_MULT  = 6'h18;
    localparam logic [5:0] MIPS_MULTU = 6'h19;
    localparam logic [5:0] MIPS_DIV   = 6'h1A;
    localparam logic [5:0] MIPS_DIVU  = 6'h1B;

    localparam int WD_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RUN   = 2'd2
    } mdu_state_t;

    // Multiply/divide operations that occupy the MDU for many cycles
    function automatic logic is_calc(input logic [5:0] op);
        case (op)
            MIPS_MULT, MIPS_MULTU, MIPS_DIV, MIPS_DIVU: return 1'b1;
            default:                                   return 1'b0;
        endcase
    endfunction

    // Direct writes of HI or LO
    function automatic logic is_mt(input logic [5:0] op);
        return (op == MIPS_MTHI) || (op == MIPS_MTLO);
    endfunction

    // Reads of HI or LO
    function automatic logic is_mf(input logic [5:0] op);
        return (op == MIPS_MFHI) || (op == MIPS_MFLO);
    endfunction

    // Multiplies use the shorter latency class
    function automatic logic is_mul(input logic [5:0] op);
        return (op == MIPS_MULT) || (op == MIPS_MULTU);
    endfunction

endpackage

// File: rtl/mdu_watchdog.sv
// Latency watchdog for an in-flight MDU operation: a down-counter loaded
// with the expected busy time plus slack, and a sticky error flag raised
// when the counter runs out while the MDU still reports busy.
module mdu_watchdog
    import mdu_issue_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [WD_CNT_W-1:0] load_val,
    input  logic                dec,
    input  logic                busy,
    output logic                err
);

    logic [WD_CNT_W-1:0] count;

    // Counter load/decrement and sticky error capture
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            err   <= 1'b0;
        end else begin
            if (load) begin
                count <= load_val;
            end else if (dec && busy && (count != '0)) begin
                count <= count - 1'b1;
            end
            if (!load && dec && busy && (count <= WD_CNT_W'(1))) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mdu_issue.sv
// E-stage initiator for the multiply/divide unit. Buffers MULT/DIV operands
// for one cycle before pulsing start, passes MTHI/MTLO straight through,
// returns MFHI/MFLO data and requests a stall while the MDU is occupied.
module mdu_issue
    import mdu_issue_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int SLACK    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [5:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        interrupt,
    input  logic        mdu_busy,
    input  logic [31:0] mdu_hi,
    input  logic [31:0] mdu_lo,
    output logic        start,
    output logic [5:0]  mdu_op,
    output logic [31:0] d1,
    output logic [31:0] d2,
    output logic        stall,
    output logic [31:0] mf_data,
    output logic        err
);

    mdu_state_t  state;
    logic [5:0]  buf_op;
    logic [31:0] buf_rs;
    logic [31:0] buf_rt;
    logic        first_run;

    logic op_calc;
    logic op_mt;
    logic req;
    logic free;
    logic accept_calc;
    logic wd_load;
    logic [WD_CNT_W-1:0] wd_val;

    assign op_calc     = is_calc(op);
    assign op_mt       = is_mt(op);
    assign req         = op_valid && (op_calc || op_mt || is_mf(op));
    assign free        = (state == ST_IDLE) && !mdu_busy;
    assign stall       = req && !free;
    assign accept_calc = req && op_calc && free && !interrupt;

    assign wd_load = (state == ST_ISSUE) && !interrupt;
    assign wd_val  = is_mul(buf_op) ? WD_CNT_W'(MULT_LAT + SLACK)
                                    : WD_CNT_W'(DIV_LAT + SLACK);

    assign mf_data = (op == MIPS_MFHI) ? mdu_hi : mdu_lo;

    // Issue FSM: buffer operands on accept, pulse start, then wait for BUSY to drop
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            buf_op    <= '0;
            buf_rs    <= '0;
            buf_rt    <= '0;
            first_run <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept_calc) begin
                        buf_op <= op;
                        buf_rs <= rs_data;
                        buf_rt <= rt_data;
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (interrupt) begin
                        state <= ST_IDLE;
                    end else begin
                        state     <= ST_RUN;
                        first_run <= 1'b1;
                    end
                end
                ST_RUN: begin
                    first_run <= 1'b0;
                    if (!first_run && !mdu_busy) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // MDU command outputs: same-cycle MT writes in IDLE, buffered op with start in ISSUE
    always_comb begin
        start  = 1'b0;
        mdu_op = '0;
        d1     = '0;
        d2     = '0;
        if (!reset) begin
            case (state)
                ST_IDLE: begin
                    if (req && op_mt && free && !interrupt) begin
                        mdu_op = op;
                        d1     = rs_data;
                    end
                end
                ST_ISSUE: begin
                    if (!interrupt) begin
                        start  = 1'b1;
                        mdu_op = buf_op;
                        d1     = buf_rs;
                        d2     = buf_rt;
                    end
                end
                default: ;
            endcase
        end
    end

    mdu_watchdog u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .load     (wd_load),
        .load_val (wd_val),
        .dec      (state == ST_RUN),
        .busy     (mdu_busy),
        .err      (err)
    );

endmodule

// File: tb/tb_mdu_issue.sv
// Directed bench for mdu_issue with a behavioural MDU model. Expected start
// transactions and MF results are queued when stimulus is driven and checked
// when the DUT produces them.
module tb_mdu_issue;
    import mdu_issue_pkg::*;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } start_exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [5:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        interrupt;
    logic        mdu_busy;
    logic [31:0] mdu_hi;
    logic [31:0] mdu_lo;
    logic        start;
    logic [5:0]  mdu_op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        stall;
    logic [31:0] mf_data;
    logic        err;

    int n_cmp  = 0;
    int n_fail = 0;

    start_exp_t  start_q[$];
    logic [31:0] mf_q[$];

    int          busy_override = 0;
    int          busy_cnt;
    logic [63:0] prod;

    mdu_issue dut (
        .clk       (clk),
        .reset     (reset),
        .op_valid  (op_valid),
        .op        (op),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .interrupt (interrupt),
        .mdu_busy  (mdu_busy),
        .mdu_hi    (mdu_hi),
        .mdu_lo    (mdu_lo),
        .start     (start),
        .mdu_op    (mdu_op),
        .d1        (d1),
        .d2        (d2),
        .stall     (stall),
        .mf_data   (mf_data),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Behavioural MDU: BUSY rises one edge after start and stays up for the op latency
    always @(posedge clk) begin
        if (reset) begin
            mdu_busy <= 1'b0;
            mdu_hi   <= '0;
            mdu_lo   <= '0;
            busy_cnt <= 0;
        end else if (start) begin
            case (mdu_op)
                MIPS_MULT:  prod = 64'($signed(d1) * $signed(d2));
                MIPS_MULTU: prod = {32'd0, d1} * {32'd0, d2};
                MIPS_DIV:   prod = {32'($signed(d1) % $signed(d2)), 32'($signed(d1) / $signed(d2))};
                default:    prod = {d1 % d2, d1 / d2};
            endcase
            mdu_hi   <= prod[63:32];
            mdu_lo   <= prod[31:0];
            mdu_busy <= 1'b1;
            if (busy_override != 0)
                busy_cnt <= busy_override;
            else
                busy_cnt <= is_mul(mdu_op) ? 5 : 10;
        end else if (mdu_busy) begin
            if (busy_cnt == 1) mdu_busy <= 1'b0;
            busy_cnt <= busy_cnt - 1;
        end else if (mdu_op == MIPS_MTHI) begin
            mdu_hi <= d1;
        end else if (mdu_op == MIPS_MTLO) begin
            mdu_lo <= d1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Start monitor: every start pulse must match the oldest queued expectation
    always @(negedge clk) begin
        #2;
        if (start === 1'b1) begin
            if (start_q.size() == 0) begin
                checkOutput("start_unexpected", 32'd1, 32'd0);
            end else begin
                start_exp_t e;
                e = start_q.pop_front();
                checkOutput("start_op", {26'd0, mdu_op}, {26'd0, e.op});
                checkOutput("start_d1", d1, e.a);
                checkOutput("start_d2", d2, e.b);
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [5:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic intr);
        @(negedge clk);
        op_valid  = v;
        op        = o;
        rs_data   = a;
        rt_data   = b;
        interrupt = intr;
        #1;
    endtask

    task automatic holdCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic issueCalc(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
        start_exp_t e;
        e.op = o;
        e.a  = a;
        e.b  = b;
        start_q.push_back(e);
        applyStimulus(1'b1, o, a, b, 1'b0);
    endtask

    // Present an MF op, hold it while stalled, then compare the returned data
    task automatic issueMf(input string tag, input logic [5:0] o, input logic [31:0] expected,
                           input int exp_stalls);
        int n;
        mf_q.push_back(expected);
        applyStimulus(1'b1, o, 32'd0, 32'd0, 1'b0);
        n = 0;
        while (stall === 1'b1 && n < 60) begin
            n++;
            holdCycle();
        end
        checkOutput({tag, "_stalls"}, n, exp_stalls);
        checkOutput({tag, "_data"}, mf_data, mf_q.pop_front());
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: observed=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset     = 1'b1;
        op_valid  = 1'b0;
        op        = '0;
        rs_data   = '0;
        rt_data   = '0;
        interrupt = 1'b0;
        holdCycle();
        holdCycle();
        checkOutput("rst_start", start, 0);
        checkOutput("rst_mdu_op", mdu_op, 0);
        checkOutput("rst_d1", d1, 0);
        checkOutput("rst_d2", d2, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_stall", stall, 0);
        reset = 1'b0;

        // MULT 7 * -3, MFLO held through ISSUE plus six RUN cycles
        issueCalc(MIPS_MULT, 32'd7, 32'hFFFFFFFD);
        checkOutput("mult_accept_start", start, 0);
        checkOutput("mult_accept_mdu_op", mdu_op, 0);
        checkOutput("mult_accept_d1", d1, 0);
        issueMf("mult_mflo", MIPS_MFLO, 32'hFFFFFFEB, 7);
        issueMf("mult_mfhi", MIPS_MFHI, 32'hFFFFFFFF, 0);

        // DIVU 100/7 with back-to-back MFHI
        issueCalc(MIPS_DIVU, 32'd100, 32'd7);
        issueMf("divu_mfhi", MIPS_MFHI, 32'd2, 12);
        checkOutput("divu_err", err, 0);

        // MTLO pass-through, then a flushed MTLO that must not write
        applyStimulus(1'b1, MIPS_MTLO, 32'h1234, 32'd0, 1'b0);
        checkOutput("mtlo_stall", stall, 0);
        checkOutput("mtlo_mdu_op", mdu_op, MIPS_MTLO);
        checkOutput("mtlo_d1", d1, 32'h1234);
        checkOutput("mtlo_start", start, 0);
        issueMf("mtlo_mflo", MIPS_MFLO, 32'h1234, 0);
        applyStimulus(1'b1, MIPS_MTLO, 32'h5678, 32'd0, 1'b1);
        checkOutput("mtlo_int_mdu_op", mdu_op, 0);
        issueMf("mtlo_int_mflo", MIPS_MFLO, 32'h1234, 0);

        // DIV cancelled by an interrupt in its ISSUE cycle
        applyStimulus(1'b1, MIPS_DIV, 32'd50, 32'd5, 1'b0);
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b1);
        checkOutput("div_int_start", start, 0);
        issueMf("div_int_mflo", MIPS_MFLO, 32'h1234, 0);
        issueMf("div_int_mfhi", MIPS_MFHI, 32'd2, 0);

        // MULT interrupted by reset in RUN, then a fresh MULTU
        issueCalc(MIPS_MULT, 32'd3, 32'd4);
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
        reset = 1'b1;
        #1;
        checkOutput("midrun_rst_start", start, 0);
        checkOutput("midrun_rst_mdu_op", mdu_op, 0);
        holdCycle();
        reset = 1'b0;
        applyStimulus(1'b1, MIPS_MFHI, 32'd0, 32'd0, 1'b0);
        checkOutput("post_rst_stall", stall, 0);
        checkOutput("post_rst_start", start, 0);
        issueCalc(MIPS_MULTU, 32'hFFFFFFFF, 32'd2);
        issueMf("multu_mfhi", MIPS_MFHI, 32'd1, 7);
        issueMf("multu_mflo", MIPS_MFLO, 32'hFFFFFFFE, 0);

        // MDU stuck busy for 20 cycles: err appears after the 9th RUN edge
        busy_override = 20;
        issueCalc(MIPS_MULT, 32'd5, 32'd5);
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            holdCycle();
            if (k == 9)  checkOutput("wd_err_before", err, 0);
            if (k == 10) checkOutput("wd_err_rise", err, 1);
        end
        issueMf("wd_mflo", MIPS_MFLO, 32'd25, 11);
        checkOutput("wd_err_sticky", err, 1);
        busy_override = 0;
        reset = 1'b1;
        holdCycle();
        reset = 1'b0;
        holdCycle();
        checkOutput("wd_err_cleared", err, 0);

        checkOutput("start_q_drained", start_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
